pe: RTL and testbench
=====================

PE -- requirements
Module: pe

Interface
REQ-001 The module SHALL have parameter num_pixels, default 4, giving the number of pixels N processed per frame slice.
REQ-002 The port list SHALL be, in order:
- Clk  in  1  rising-edge clock
- Ack  in  1  done-state acknowledge
- Reset  in  1  asynchronous, active-low reset
- red_exp / green_exp / blue_exp  in  8 each  expected background colour
- threshold  in  8  per-channel match tolerance
- desired_bg_r / desired_bg_g / desired_bg_b  in  8 each  replacement colour
- Start_Sum  in  1  start the averaging pass
- Start_BgRemoval  in  1  start the replacement pass
- red_in / green_in / blue_in  in  8*N each  pixel i occupies bits [8i+7:8i]
- red_out / green_out / blue_out  out  8*N each  processed pixels, same packing
- Qi, Qbgi, Qbg, Qbgd, Qsi, Qs, Qsd  out  1 each  one-hot state flags
- red_sum / green_sum / blue_sum  out  8*N each  per-channel mean, zero-extended

Function
REQ-003 The FSM SHALL have seven states, each flagged by its Q output: I (idle), SI/S/SD (sum init/run/done), BGI/BG/BGD (removal init/run/done); exactly one Q SHALL be high.
REQ-004 I transitions: Start_Sum=1 -> SI; else Start_BgRemoval=1 -> BGI; else stay. Start_Sum has priority on simultaneous starts.
REQ-005 Start inputs SHALL be ignored in every state except I.
REQ-006 SI SHALL latch red_in/green_in/blue_in, clear the three accumulators and pixel index, then go to S.
REQ-007 S SHALL add one pixel per cycle (index 0..N-1) to 16-bit per-channel accumulators; after pixel N-1 it SHALL register floor(acc/N) into bits [7:0] of each *_sum output, zero the upper bits, and go to SD.
REQ-008 Sum latency SHALL be N+2 clocks from the edge sampling Start_Sum to Qsd high (6 for N=4).
REQ-009 BGI SHALL latch pixels, *_exp, threshold and desired_bg_*, clear the index, then go to BG.
REQ-010 BG SHALL process one pixel per cycle: background iff |r-red_exp|<=threshold AND |g-green_exp|<=threshold AND |b-blue_exp|<=threshold (unsigned 8-bit differences, inclusive compare). Background pixels SHALL be written to *_out as desired_bg_*; others unchanged. After pixel N-1 go to BGD.
REQ-011 Removal latency SHALL be N+2 clocks from Start_BgRemoval sample to Qbgd high.
REQ-012 SD and BGD SHALL return to I on a clock edge with Ack=1 and hold while Ack=0; a single-cycle pass-through occurs if Ack is already high.
REQ-013 *_sum SHALL change only on the S->SD edge; *_out SHALL change only in BG; both hold their values otherwise, including across later passes of the other kind.
REQ-014 threshold=0 SHALL replace only exact colour matches; threshold=255 SHALL replace every pixel.

Reset
REQ-015 Reset low SHALL asynchronously force state I (Qi=1, other Q=0) and clear all *_out, *_sum, accumulators, index and latched registers to 0, including mid-pass; a pass aborted by reset SHALL NOT resume.

Structure
REQ-016 A shared package SHALL hold the state encoding constants and the 8-bit pixel channel width.
REQ-017 One sub-module, pe_pixel_match, SHALL implement the combinational three-channel threshold compare of REQ-010.

Verification
REQ-018 Sum: pixels {p3..p0} = (61,133,198)x3, p0=(204,0,0), Start_Sum pulse, Ack=1 -> Qsd after 6 clocks, red/green/blue_sum = 96/99/148.
REQ-019 Removal: same pixels, exp 96/99/148, threshold 60, desired 106/168/79 -> p0 stays 204/0/0, p1..p3 become 106/168/79, Qbgd after 6 clocks.
REQ-020 Boundary: exp 100/100/100, threshold 10, pixels 110/90/100 and 111/100/100 -> first replaced, second kept.
REQ-021 Handshake: Ack=0 during sum -> Qsd held 10+ clocks; Ack=1 -> Qi next clock; Start_BgRemoval pulsed in SD is ignored.
REQ-022 Reset mid-BG: Reset low during BG -> Qi=1 immediately, all outputs 0; a following Start_Sum runs normally.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared definitions for the pixel engine: channel width, accumulator width,
// FSM state encoding and a small unsigned distance helper.
package pe_pkg;

  localparam int unsigned chan_w = 8;
  localparam int unsigned acc_w  = 16;

  typedef enum logic [2:0] {
    st_i   = 3'd0,
    st_si  = 3'd1,
    st_s   = 3'd2,
    st_sd  = 3'd3,
    st_bgi = 3'd4,
    st_bg  = 3'd5,
    st_bgd = 3'd6
  } state_t;

  // Unsigned |a - b| without leaving the 8-bit domain.
  function automatic logic [chan_w-1:0] abs_diff(input logic [chan_w-1:0] a,
                                                 input logic [chan_w-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/pe_pixel_match.sv
// Combinational background test for one pixel: every channel must sit within
// the tolerance of the expected colour (inclusive).
module pe_pixel_match
  import pe_pkg::*;
(
  input  logic [chan_w-1:0] red,
  input  logic [chan_w-1:0] green,
  input  logic [chan_w-1:0] blue,
  input  logic [chan_w-1:0] red_exp,
  input  logic [chan_w-1:0] green_exp,
  input  logic [chan_w-1:0] blue_exp,
  input  logic [chan_w-1:0] threshold,
  output logic              is_bg
);

  // All three channel distances are compared against the same tolerance.
  always_comb begin
    is_bg = (abs_diff(red,   red_exp)   <= threshold) &&
            (abs_diff(green, green_exp) <= threshold) &&
            (abs_diff(blue,  blue_exp)  <= threshold);
  end

endmodule

// File: rtl/pe.sv
// Pixel engine: averaging pass and background-replacement pass over a slice
// of num_pixels pixels, one pixel per clock, with an Ack handshake at the end.
module pe
  import pe_pkg::*;
#(
  parameter int num_pixels = 4
) (
  input  logic                         Clk,
  input  logic                         Ack,
  input  logic                         Reset,
  input  logic [chan_w-1:0]            red_exp,
  input  logic [chan_w-1:0]            green_exp,
  input  logic [chan_w-1:0]            blue_exp,
  input  logic [chan_w-1:0]            threshold,
  input  logic [chan_w-1:0]            desired_bg_r,
  input  logic [chan_w-1:0]            desired_bg_g,
  input  logic [chan_w-1:0]            desired_bg_b,
  input  logic                         Start_Sum,
  input  logic                         Start_BgRemoval,
  input  logic [chan_w*num_pixels-1:0] red_in,
  input  logic [chan_w*num_pixels-1:0] green_in,
  input  logic [chan_w*num_pixels-1:0] blue_in,
  output logic [chan_w*num_pixels-1:0] red_out,
  output logic [chan_w*num_pixels-1:0] green_out,
  output logic [chan_w*num_pixels-1:0] blue_out,
  output logic                         Qi,
  output logic                         Qbgi,
  output logic                         Qbg,
  output logic                         Qbgd,
  output logic                         Qsi,
  output logic                         Qs,
  output logic                         Qsd,
  output logic [chan_w*num_pixels-1:0] red_sum,
  output logic [chan_w*num_pixels-1:0] green_sum,
  output logic [chan_w*num_pixels-1:0] blue_sum
);

  localparam int slice_w = chan_w * num_pixels;
  localparam int idx_w   = (num_pixels > 1) ? $clog2(num_pixels) : 1;

  state_t             state, state_nx;
  logic [idx_w-1:0]   idx;
  logic               last_px;

  logic [slice_w-1:0] red_lat, green_lat, blue_lat;
  logic [chan_w-1:0]  red_exp_lat, green_exp_lat, blue_exp_lat, thr_lat;
  logic [chan_w-1:0]  des_r_lat, des_g_lat, des_b_lat;

  logic [acc_w-1:0]   acc_r, acc_g, acc_b;
  logic [acc_w-1:0]   acc_r_nx, acc_g_nx, acc_b_nx;
  logic [chan_w-1:0]  mean_r, mean_g, mean_b;
  logic [chan_w-1:0]  cur_r, cur_g, cur_b;
  logic               is_bg;

  assign last_px = (idx == idx_w'(num_pixels - 1));

  // One-hot state flags decoded from the state register.
  assign Qi   = (state == st_i);
  assign Qsi  = (state == st_si);
  assign Qs   = (state == st_s);
  assign Qsd  = (state == st_sd);
  assign Qbgi = (state == st_bgi);
  assign Qbg  = (state == st_bg);
  assign Qbgd = (state == st_bgd);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= st_i;
    else        state <= state_nx;
  end

  // Next-state logic; starts are only looked at in idle.
  // NOTE: the default-first assignment keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      st_i: begin
        if (Start_Sum)            state_nx = st_si;
        else if (Start_BgRemoval) state_nx = st_bgi;
      end
      st_si:   state_nx = st_s;
      st_s:    if (last_px) state_nx = st_sd;
      st_sd:   if (Ack) state_nx = st_i;
      st_bgi:  state_nx = st_bg;
      st_bg:   if (last_px) state_nx = st_bgd;
      st_bgd:  if (Ack) state_nx = st_i;
      default: state_nx = st_i;
    endcase
  end

  // Select the pixel under the index and form the running sums and means.
  always_comb begin
    cur_r = '0;
    cur_g = '0;
    cur_b = '0;
    for (int i = 0; i < num_pixels; i++) begin
      if (idx == idx_w'(i)) begin
        cur_r = red_lat[chan_w*i +: chan_w];
        cur_g = green_lat[chan_w*i +: chan_w];
        cur_b = blue_lat[chan_w*i +: chan_w];
      end
    end
    acc_r_nx = acc_r + acc_w'(cur_r);
    acc_g_nx = acc_g + acc_w'(cur_g);
    acc_b_nx = acc_b + acc_w'(cur_b);
    mean_r   = chan_w'(acc_r_nx / acc_w'(num_pixels));
    mean_g   = chan_w'(acc_g_nx / acc_w'(num_pixels));
    mean_b   = chan_w'(acc_b_nx / acc_w'(num_pixels));
  end

  pe_pixel_match u_match (
    .red       (cur_r),
    .green     (cur_g),
    .blue      (cur_b),
    .red_exp   (red_exp_lat),
    .green_exp (green_exp_lat),
    .blue_exp  (blue_exp_lat),
    .threshold (thr_lat),
    .is_bg     (is_bg)
  );

  // Input capture in the init states, index walk and accumulation in the run states.
  // NOTE: the latched slice is cleared on reset as well, so nothing from an aborted pass survives.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      red_lat       <= '0;
      green_lat     <= '0;
      blue_lat      <= '0;
      red_exp_lat   <= '0;
      green_exp_lat <= '0;
      blue_exp_lat  <= '0;
      thr_lat       <= '0;
      des_r_lat     <= '0;
      des_g_lat     <= '0;
      des_b_lat     <= '0;
      acc_r         <= '0;
      acc_g         <= '0;
      acc_b         <= '0;
      idx           <= '0;
    end else begin
      case (state)
        st_si: begin
          red_lat   <= red_in;
          green_lat <= green_in;
          blue_lat  <= blue_in;
          acc_r     <= '0;
          acc_g     <= '0;
          acc_b     <= '0;
          idx       <= '0;
        end
        st_s: begin
          acc_r <= acc_r_nx;
          acc_g <= acc_g_nx;
          acc_b <= acc_b_nx;
          idx   <= idx + 1'b1;
        end
        st_bgi: begin
          red_lat       <= red_in;
          green_lat     <= green_in;
          blue_lat      <= blue_in;
          red_exp_lat   <= red_exp;
          green_exp_lat <= green_exp;
          blue_exp_lat  <= blue_exp;
          thr_lat       <= threshold;
          des_r_lat     <= desired_bg_r;
          des_g_lat     <= desired_bg_g;
          des_b_lat     <= desired_bg_b;
          idx           <= '0;
        end
        st_bg:   idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  // Means are published only on the final accumulation step.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      red_sum   <= '0;
      green_sum <= '0;
      blue_sum  <= '0;
    end else if (state == st_s && last_px) begin
      red_sum   <= slice_w'(mean_r);
      green_sum <= slice_w'(mean_g);
      blue_sum  <= slice_w'(mean_b);
    end
  end

  // Replacement pass rewrites the current slot; all other slots hold.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
    end else if (state == st_bg) begin
      for (int i = 0; i < num_pixels; i++) begin
        if (idx == idx_w'(i)) begin
          red_out[chan_w*i +: chan_w]   <= is_bg ? des_r_lat : cur_r;
          green_out[chan_w*i +: chan_w] <= is_bg ? des_g_lat : cur_g;
          blue_out[chan_w*i +: chan_w]  <= is_bg ? des_b_lat : cur_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe: directed passes with a behavioural model of
// means and replacements, plus a per-cycle compare of held outputs.
module tb_pe;

  localparam int N = 4;
  localparam int W = 8 * N;

  typedef int px_t [N];

  logic         Clk = 1'b0;
  logic         Ack, Reset;
  logic [7:0]   red_exp, green_exp, blue_exp, threshold;
  logic [7:0]   desired_bg_r, desired_bg_g, desired_bg_b;
  logic         Start_Sum, Start_BgRemoval;
  logic [W-1:0] red_in, green_in, blue_in;
  logic [W-1:0] red_out, green_out, blue_out;
  logic         Qi, Qbgi, Qbg, Qbgd, Qsi, Qs, Qsd;
  logic [W-1:0] red_sum, green_sum, blue_sum;

  int checks   = 0;
  int failures = 0;

  // Model state: stimulus pixels and the values the held outputs must show.
  px_t px_r, px_g, px_b;
  px_t m_out_r, m_out_g, m_out_b;
  int  m_sum_r, m_sum_g, m_sum_b;
  bit  cmp_sum_en = 1'b0;
  bit  cmp_out_en = 1'b0;

  pe #(.num_pixels(N)) dut (
    .Clk             (Clk),
    .Ack             (Ack),
    .Reset           (Reset),
    .red_exp         (red_exp),
    .green_exp       (green_exp),
    .blue_exp        (blue_exp),
    .threshold       (threshold),
    .desired_bg_r    (desired_bg_r),
    .desired_bg_g    (desired_bg_g),
    .desired_bg_b    (desired_bg_b),
    .Start_Sum       (Start_Sum),
    .Start_BgRemoval (Start_BgRemoval),
    .red_in          (red_in),
    .green_in        (green_in),
    .blue_in         (blue_in),
    .red_out         (red_out),
    .green_out       (green_out),
    .blue_out        (blue_out),
    .Qi              (Qi),
    .Qbgi            (Qbgi),
    .Qbg             (Qbg),
    .Qbgd            (Qbgd),
    .Qsi             (Qsi),
    .Qs              (Qs),
    .Qsd             (Qsd),
    .red_sum         (red_sum),
    .green_sum       (green_sum),
    .blue_sum        (blue_sum)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] pack(input px_t a);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[8*i +: 8] = 8'(a[i]);
    return v;
  endfunction

  function automatic int mean_of(input px_t a);
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += a[i];
    return s / N;
  endfunction

  function automatic bit near(input int a, input int e, input int t);
    int d;
    d = a - e;
    if (d < 0) d = -d;
    return d <= t;
  endfunction

  task automatic set_px(input px_t r, input px_t g, input px_t b);
    px_r = r; px_g = g; px_b = b;
    red_in = pack(r); green_in = pack(g); blue_in = pack(b);
  endtask

  task automatic set_cfg(input int er, input int eg, input int eb, input int t,
                         input int dr, input int dg, input int db);
    red_exp = 8'(er); green_exp = 8'(eg); blue_exp = 8'(eb); threshold = 8'(t);
    desired_bg_r = 8'(dr); desired_bg_g = 8'(dg); desired_bg_b = 8'(db);
  endtask

  task automatic model_sum();
    m_sum_r = mean_of(px_r);
    m_sum_g = mean_of(px_g);
    m_sum_b = mean_of(px_b);
  endtask

  task automatic model_bg();
    for (int i = 0; i < N; i++) begin
      if (near(px_r[i], int'(red_exp), int'(threshold)) &&
          near(px_g[i], int'(green_exp), int'(threshold)) &&
          near(px_b[i], int'(blue_exp), int'(threshold))) begin
        m_out_r[i] = int'(desired_bg_r);
        m_out_g[i] = int'(desired_bg_g);
        m_out_b[i] = int'(desired_bg_b);
      end else begin
        m_out_r[i] = px_r[i];
        m_out_g[i] = px_g[i];
        m_out_b[i] = px_b[i];
      end
    end
  endtask

  task automatic model_clear();
    m_sum_r = 0; m_sum_g = 0; m_sum_b = 0;
    for (int i = 0; i < N; i++) begin
      m_out_r[i] = 0; m_out_g[i] = 0; m_out_b[i] = 0;
    end
  endtask

  // Per-cycle compare: one-hot flags always; held outputs whenever enabled.
  always @(negedge Clk) begin
    check("q_onehot", 64'($countones({Qi, Qsi, Qs, Qsd, Qbgi, Qbg, Qbgd})), 64'd1);
    if (cmp_sum_en) begin
      check("cmp_red_sum",   64'(red_sum),   64'(m_sum_r));
      check("cmp_green_sum", 64'(green_sum), 64'(m_sum_g));
      check("cmp_blue_sum",  64'(blue_sum),  64'(m_sum_b));
    end
    if (cmp_out_en) begin
      check("cmp_red_out",   64'(red_out),   64'(pack(m_out_r)));
      check("cmp_green_out", 64'(green_out), 64'(pack(m_out_g)));
      check("cmp_blue_out",  64'(blue_out),  64'(pack(m_out_b)));
    end
  end

  // Pulse a start at a falling edge and count rising edges (the sampling edge
  // is edge 1) until the matching done flag is seen.
  task automatic run_pass(input string name, input bit do_sum, input bit do_bg);
    int lat;
    @(negedge Clk);
    Start_Sum       = do_sum;
    Start_BgRemoval = do_bg;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge Clk);
      @(negedge Clk);
      Start_Sum       = 1'b0;
      Start_BgRemoval = 1'b0;
      if (n == 1) check({name, "_init_state"}, 64'(do_sum ? Qsi : Qbgi), 64'd1);
      if (n == 2) check({name, "_run_state"},  64'(do_sum ? Qs  : Qbg),  64'd1);
      if (do_sum ? Qsd : Qbgd) begin
        lat = n;
        break;
      end
    end
    check({name, "_latency"}, 64'(lat), 64'(N + 2));
  endtask

  task automatic sum_pass(input string name, input bit also_bg);
    cmp_sum_en = 1'b0;
    run_pass(name, 1'b1, also_bg);
    model_sum();
    cmp_sum_en = 1'b1;
  endtask

  task automatic bg_pass(input string name);
    cmp_out_en = 1'b0;
    run_pass(name, 1'b0, 1'b1);
    model_bg();
    cmp_out_en = 1'b1;
  endtask

  task automatic expect_idle(input string name);
    @(posedge Clk);
    @(negedge Clk);
    check(name, 64'(Qi), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int held;
    Reset = 1'b0; Ack = 1'b1; Start_Sum = 1'b0; Start_BgRemoval = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    set_px('{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0});
    model_clear();
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_qi",      64'(Qi), 64'd1);
    check("rst_q_other", 64'({Qsi, Qs, Qsd, Qbgi, Qbg, Qbgd}), 64'd0);
    check("rst_sums",    64'(red_sum | green_sum | blue_sum), 64'd0);
    check("rst_outs",    64'(red_out | green_out | blue_out), 64'd0);
    cmp_sum_en = 1'b1;
    cmp_out_en = 1'b1;
    Reset = 1'b1;

    // Averaging pass on the reference slice.
    set_px('{204, 61, 61, 61}, '{0, 133, 133, 133}, '{0, 198, 198, 198});
    sum_pass("sum", 1'b0);
    check("sum_red_lit",   64'(red_sum),   64'd96);
    check("sum_green_lit", 64'(green_sum), 64'd99);
    check("sum_blue_lit",  64'(blue_sum),  64'd148);
    expect_idle("sum_ack_idle");

    // Replacement pass on the same slice.
    set_cfg(96, 99, 148, 60, 106, 168, 79);
    bg_pass("bg");
    check("bg_red_lit",   64'(red_out),   64'h6A6A6ACC);
    check("bg_green_lit", 64'(green_out), 64'hA8A8A800);
    check("bg_blue_lit",  64'(blue_out),  64'h4F4F4F00);
    expect_idle("bg_ack_idle");

    // Tolerance edge: distance 10 replaced, distance 11 kept.
    set_px('{110, 111, 100, 89}, '{90, 100, 100, 100}, '{100, 100, 100, 100});
    set_cfg(100, 100, 100, 10, 1, 2, 3);
    bg_pass("edge");
    check("edge_red_lit",   64'(red_out),   64'h59016F01);
    check("edge_green_lit", 64'(green_out), 64'h64026402);
    expect_idle("edge_ack_idle");

    // Zero tolerance replaces exact matches only.
    set_cfg(100, 100, 100, 0, 7, 8, 9);
    bg_pass("thr0");
    check("thr0_red_lit", 64'(red_out), 64'h59076F6E);
    expect_idle("thr0_ack_idle");

    // Full tolerance replaces everything.
    set_cfg(0, 0, 0, 255, 200, 201, 202);
    bg_pass("thr255");
    check("thr255_red_lit",   64'(red_out),   64'hC8C8C8C8);
    check("thr255_green_lit", 64'(green_out), 64'hC9C9C9C9);
    check("sum_held_red",     64'(red_sum),   64'd96);
    expect_idle("thr255_ack_idle");

    // Handshake: simultaneous starts pick the sum; done holds without Ack.
    set_px('{10, 20, 30, 40}, '{255, 255, 255, 255}, '{0, 1, 2, 3});
    Ack = 1'b0;
    sum_pass("hs", 1'b1);
    check("hs_red_lit",   64'(red_sum),   64'd25);
    check("hs_green_lit", 64'(green_sum), 64'd255);
    check("hs_blue_lit",  64'(blue_sum),  64'd1);
    held = 0;
    for (int c = 0; c < 12; c++) begin
      Start_BgRemoval = (c == 4);
      @(posedge Clk);
      @(negedge Clk);
      if (Qsd) held++;
    end
    Start_BgRemoval = 1'b0;
    check("hs_sd_hold", 64'(held), 64'd12);
    Ack = 1'b1;
    expect_idle("hs_ack_idle");
    expect_idle("hs_start_ignored");

    // Reset in the middle of a replacement pass.
    set_cfg(96, 99, 148, 60, 106, 168, 79);
    cmp_out_en = 1'b0;
    @(negedge Clk);
    Start_BgRemoval = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    Start_BgRemoval = 1'b0;
    repeat (2) begin
      @(posedge Clk);
      @(negedge Clk);
    end
    check("mid_in_bg", 64'(Qbg), 64'd1);
    #1;
    Reset = 1'b0;
    model_clear();
    #1;
    check("mid_rst_qi",      64'(Qi), 64'd1);
    check("mid_rst_q_other", 64'({Qsi, Qs, Qsd, Qbgi, Qbg, Qbgd}), 64'd0);
    check("mid_rst_outs",    64'(red_out | green_out | blue_out), 64'd0);
    check("mid_rst_sums",    64'(red_sum | green_sum | blue_sum), 64'd0);
    @(negedge Clk);
    Reset = 1'b1;
    cmp_out_en = 1'b1;
    repeat (3) expect_idle("mid_no_resume");
    sum_pass("post", 1'b0);
    check("post_red_lit", 64'(red_sum), 64'd25);
    expect_idle("post_ack_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
